// File: rtl/cl_sde_pkg.sv
// Shared definitions for the SDE stream generator: register map, FSM states,
// and the last-beat byte-enable helper.
package cl_sde_pkg;

   localparam logic [11:0] ADDR_CTRL  = 12'h000;
   localparam logic [11:0] ADDR_LEN   = 12'h004;
   localparam logic [11:0] ADDR_NPKT  = 12'h008;
   localparam logic [11:0] ADDR_SEED  = 12'h00C;
   localparam logic [11:0] ADDR_GAP   = 12'h010;
   localparam logic [11:0] ADDR_PKTS  = 12'h014;
   localparam logic [11:0] ADDR_BEATS = 12'h018;

   localparam logic [15:0] LEN_RST = 16'd64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } gen_state_t;

   // Byte enables for the final beat; a whole-beat remainder keeps every byte.
   function automatic logic [63:0] keep_mask(input logic [5:0] len);
      if (len == 6'd0) keep_mask = '1;
      else             keep_mask = (64'd1 << len) - 64'd1;
   endfunction

endpackage

// File: rtl/cl_sde_stream_gen_regs.sv
// Configuration register file for the stream generator: address decode,
// write strobes for go/stop, and registered read-back with a one-cycle ack.
module cl_sde_stream_gen_regs (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] cfg_addr,
   input  logic        cfg_wr,
   input  logic        cfg_rd,
   input  logic [31:0] cfg_wdata,
   output logic        cfg_ack,
   output logic [31:0] cfg_rdata,
   input  logic        busy,
   input  logic [31:0] pkts_sent,
   input  logic [31:0] beats_sent,
   output logic        go_pulse,
   output logic        stop_pulse,
   output logic        cont,
   output logic        cont_nxt,
   output logic [15:0] len,
   output logic [15:0] gap,
   output logic [31:0] npkt,
   output logic [31:0] seed
);
   import cl_sde_pkg::*;

   logic        cont_q, cont_d;
   logic [15:0] len_q, len_d;
   logic [15:0] gap_q, gap_d;
   logic [31:0] npkt_q, npkt_d;
   logic [31:0] seed_q, seed_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   logic        wr_ctrl;

   assign wr_ctrl    = cfg_wr && (cfg_addr == ADDR_CTRL);
   assign go_pulse   = wr_ctrl && cfg_wdata[0];
   assign stop_pulse = wr_ctrl && cfg_wdata[2];

   // Write decode and read mux; the FSM sees the continuous bit being
   // written alongside go so a go+continuous write starts correctly.
   always_comb begin
      cont_d  = cont_q;
      len_d   = len_q;
      gap_d   = gap_q;
      npkt_d  = npkt_q;
      seed_d  = seed_q;
      ack_d   = cfg_wr || cfg_rd;
      rdata_d = '0;
      if (cfg_wr) begin
         case (cfg_addr)
            ADDR_CTRL: cont_d = cfg_wdata[1];
            ADDR_LEN:  len_d  = cfg_wdata[15:0];
            ADDR_NPKT: npkt_d = cfg_wdata;
            ADDR_SEED: seed_d = cfg_wdata;
            ADDR_GAP:  gap_d  = cfg_wdata[15:0];
            default:   ;
         endcase
      end
      if (cfg_rd) begin
         case (cfg_addr)
            ADDR_CTRL:  rdata_d = {29'h0, busy, cont_q, 1'b0};
            ADDR_LEN:   rdata_d = {16'h0, len_q};
            ADDR_NPKT:  rdata_d = npkt_q;
            ADDR_SEED:  rdata_d = seed_q;
            ADDR_GAP:   rdata_d = {16'h0, gap_q};
            ADDR_PKTS:  rdata_d = pkts_sent;
            ADDR_BEATS: rdata_d = beats_sent;
            default:    rdata_d = '0;
         endcase
      end
   end

   // Register state and the registered access response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_q  <= 1'b0;
         len_q   <= LEN_RST;
         gap_q   <= '0;
         npkt_q  <= '0;
         seed_q  <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         cont_q  <= cont_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         npkt_q  <= npkt_d;
         seed_q  <= seed_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   assign cfg_ack   = ack_q;
   assign cfg_rdata = rdata_q;
   assign cont      = cont_q;
   assign cont_nxt  = cont_d;
   assign len       = len_q;
   assign gap       = gap_q;
   assign npkt      = npkt_q;
   assign seed      = seed_q;

endmodule

// File: rtl/cl_sde_stream_gen.sv
// Programmable AXI-Stream word-counter packet generator feeding the SDE
// sink/loopback stage. Lane i of each beat carries W+i; user carries
// {beat index, packet sequence}.
//
// state | meaning
// IDLE  | waiting for go; stream outputs held at zero
// SEND  | presenting a beat; advances on valid && ready
// GAP   | inter-packet idle, down-counter terminates at 1
module cl_sde_stream_gen #(
   parameter  int DATA_WIDTH = 512,
   localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           cfg_addr,
   input  logic                  cfg_wr,
   input  logic                  cfg_rd,
   input  logic [31:0]           cfg_wdata,
   output logic                  cfg_ack,
   output logic [31:0]           cfg_rdata,
   output logic                  ots_valid,
   output logic                  ots_last,
   output logic [DATA_WIDTH-1:0] ots_data,
   output logic [KEEP_WIDTH-1:0] ots_keep,
   output logic [63:0]           ots_user,
   input  logic                  ots_ready
);
   import cl_sde_pkg::*;

   localparam int LANES      = DATA_WIDTH / 32;
   localparam int BEAT_SHIFT = $clog2(KEEP_WIDTH);

   logic        go_pulse, stop_pulse, cont, cont_nxt;
   logic [15:0] len_reg, gap_reg, len_eff;
   logic [31:0] npkt_reg, seed_reg;
   logic        busy;

   gen_state_t            state_q, state_d;
   logic [31:0]           w_q, w_d;
   logic [31:0]           beat_q, beat_d;
   logic [31:0]           seq_q, seq_d;
   logic [31:0]           pkts_q, pkts_d;
   logic [31:0]           beats_q, beats_d;
   logic [15:0]           gap_cnt_q, gap_cnt_d;
   logic                  stop_pend_q, stop_pend_d;
   logic [15:0]           len_pkt_q, len_pkt_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [KEEP_WIDTH-1:0] keep_q, keep_d;
   logic [63:0]           user_q, user_d;
   logic                  accept;
   logic [31:0]           last_idx_d;

   cl_sde_stream_gen_regs u_regs (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_addr   (cfg_addr),
      .cfg_wr     (cfg_wr),
      .cfg_rd     (cfg_rd),
      .cfg_wdata  (cfg_wdata),
      .cfg_ack    (cfg_ack),
      .cfg_rdata  (cfg_rdata),
      .busy       (busy),
      .pkts_sent  (pkts_q),
      .beats_sent (beats_q),
      .go_pulse   (go_pulse),
      .stop_pulse (stop_pulse),
      .cont       (cont),
      .cont_nxt   (cont_nxt),
      .len        (len_reg),
      .gap        (gap_reg),
      .npkt       (npkt_reg),
      .seed       (seed_reg)
   );

   assign busy    = (state_q != IDLE);
   assign len_eff = (len_reg == 16'd0) ? 16'd1 : len_reg;

   // Next-state logic plus next values of the registered stream outputs,
   // so a held beat stays bit-identical while ready is low.
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      beat_d      = beat_q;
      seq_d       = seq_q;
      pkts_d      = pkts_q;
      beats_d     = beats_q;
      gap_cnt_d   = gap_cnt_q;
      stop_pend_d = stop_pend_q;
      len_pkt_d   = len_pkt_q;
      accept      = valid_q && ots_ready;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (go_pulse) begin
               w_d       = seed_reg;
               seq_d     = '0;
               beat_d    = '0;
               pkts_d    = '0;
               beats_d   = '0;
               len_pkt_d = len_eff;
               if ((npkt_reg != 32'd0) || cont_nxt) state_d = SEND;
            end
         end
         SEND: begin
            if (stop_pulse) stop_pend_d = 1'b1;
            if (accept) begin
               w_d     = w_q + 32'(LANES);
               beats_d = beats_q + 32'd1;
               if (last_q) begin
                  seq_d     = seq_q + 32'd1;
                  pkts_d    = pkts_q + 32'd1;
                  beat_d    = '0;
                  len_pkt_d = len_eff;
                  if ((!cont && (seq_q + 32'd1 == npkt_reg)) || stop_pend_d) begin
                     state_d     = IDLE;
                     stop_pend_d = 1'b0;
                  end else if (gap_reg != 16'd0) begin
                     state_d   = GAP;
                     gap_cnt_d = gap_reg;
                  end
               end else begin
                  beat_d = beat_q + 32'd1;
               end
            end
         end
         GAP: begin
            // The previous packet is already complete, so a stop ends the run here.
            if (stop_pulse || stop_pend_q) begin
               state_d     = IDLE;
               stop_pend_d = 1'b0;
            end else if (gap_cnt_q <= 16'd1) begin
               state_d = SEND;
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d    = (state_d == SEND);
      data_d     = '0;
      last_d     = 1'b0;
      keep_d     = '0;
      user_d     = '0;
      last_idx_d = {16'h0, (len_pkt_d - 16'd1) >> BEAT_SHIFT};
      if (valid_d) begin
         for (int i = 0; i < LANES; i++) data_d[32*i +: 32] = w_d + 32'(i);
         last_d = (beat_d == last_idx_d);
         keep_d = last_d ? keep_mask(len_pkt_d[5:0]) : '1;
         user_d = {beat_d, seq_d};
      end
   end

   // FSM, counters and registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         w_q         <= '0;
         beat_q      <= '0;
         seq_q       <= '0;
         pkts_q      <= '0;
         beats_q     <= '0;
         gap_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         len_pkt_q   <= LEN_RST;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         data_q      <= '0;
         keep_q      <= '0;
         user_q      <= '0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         beat_q      <= beat_d;
         seq_q       <= seq_d;
         pkts_q      <= pkts_d;
         beats_q     <= beats_d;
         gap_cnt_q   <= gap_cnt_d;
         stop_pend_q <= stop_pend_d;
         len_pkt_q   <= len_pkt_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         data_q      <= data_d;
         keep_q      <= keep_d;
         user_q      <= user_d;
      end
   end

   assign ots_valid = valid_q;
   assign ots_last  = last_q;
   assign ots_data  = data_q;
   assign ots_keep  = keep_q;
   assign ots_user  = user_q;

endmodule

// File: tb/tb_cl_sde_stream_gen.sv
// Scoreboard bench for cl_sde_stream_gen: stimulus pushes expected beats,
// a negedge monitor compares every presented beat against the queue head.
module tb_cl_sde_stream_gen;
   import cl_sde_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [11:0]  cfg_addr = '0;
   logic         cfg_wr = 1'b0;
   logic         cfg_rd = 1'b0;
   logic [31:0]  cfg_wdata = '0;
   logic         cfg_ack;
   logic [31:0]  cfg_rdata;
   logic         ots_valid, ots_last;
   logic [511:0] ots_data;
   logic [63:0]  ots_keep, ots_user;
   logic         ots_ready = 1'b1;
   logic         rnd_ready = 1'b0;

   int cyc = 0;
   int wr_cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
      logic [63:0]  user;
   } beat_t;

   beat_t       exp_q[$];
   int          acc_cyc[$];
   logic [31:0] acc_l0[$];
   logic [31:0] acc_l15[$];
   logic [63:0] acc_keep[$];
   logic [63:0] acc_user[$];

   cl_sde_stream_gen #(.DATA_WIDTH(512)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_addr  (cfg_addr),
      .cfg_wr    (cfg_wr),
      .cfg_rd    (cfg_rd),
      .cfg_wdata (cfg_wdata),
      .cfg_ack   (cfg_ack),
      .cfg_rdata (cfg_rdata),
      .ots_valid (ots_valid),
      .ots_last  (ots_last),
      .ots_data  (ots_data),
      .ots_keep  (ots_keep),
      .ots_user  (ots_user),
      .ots_ready (ots_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      ots_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && ots_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got beat lane0=%0h user=%0h expected no beat",
                     ots_data[31:0], ots_user);
         end else begin
            chk("beat_data", ots_data, exp_q[0].data);
            chk("beat_ctl", 512'({ots_keep, ots_last, ots_user}),
                512'({exp_q[0].keep, exp_q[0].last, exp_q[0].user}));
            if (ots_ready) begin
               acc_cyc.push_back(cyc);
               acc_l0.push_back(ots_data[31:0]);
               acc_l15.push_back(ots_data[511:480]);
               acc_keep.push_back(ots_keep);
               acc_user.push_back(ots_user);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic push_pkts(input logic [31:0] seed, input int len, input int npkt, input int seq0);
      logic [31:0] w;
      int eff, nb, rem;
      beat_t e;
      w   = seed;
      eff = (len == 0) ? 1 : len;
      nb  = (eff + 63) / 64;
      rem = eff % 64;
      for (int p = 0; p < npkt; p++) begin
         for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int i = 0; i < 16; i++) e.data[32*i +: 32] = w + 32'(i);
            e.last = (b == nb - 1);
            e.keep = (e.last && rem != 0) ? ((64'd1 << rem) - 64'd1) : '1;
            e.user = {32'(b), 32'(seq0 + p)};
            exp_q.push_back(e);
            w = w + 32'd16;
         end
      end
   endtask

   task automatic clear_log();
      acc_cyc.delete();
      acc_l0.delete();
      acc_l15.delete();
      acc_keep.delete();
      acc_user.delete();
   endtask

   task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      wr_cyc    = cyc;
      @(posedge clk); #1;
      cfg_wr    = 1'b0;
   endtask

   task automatic cfg_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      @(posedge clk); #1;
      cfg_addr = a;
      cfg_rd   = 1'b1;
      @(posedge clk); #1;
      cfg_rd   = 1'b0;
      chk({name, "_ack"}, 512'(cfg_ack), 512'd1);
      chk(name, 512'(cfg_rdata), 512'(exp));
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(name, 512'(exp_q.size()), 512'd0);
      exp_q.delete();
      repeat (6) @(posedge clk);
   endtask

   initial begin
      int go_cyc;

      // reset values
      #1 rst_n = 1'b0;
      #3;
      chk("rst_ctl_out", 512'({ots_valid, ots_last, ots_keep, ots_user, cfg_ack, cfg_rdata}), 512'd0);
      chk("rst_data", ots_data, 512'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cfg_check("rst_len", ADDR_LEN, 32'd64);
      cfg_check("rst_ctrl", ADDR_CTRL, 32'd0);

      // three single-beat packets back-to-back
      cfg_write(ADDR_LEN, 32'd64);
      cfg_write(ADDR_NPKT, 32'd3);
      cfg_write(ADDR_GAP, 32'd0);
      cfg_write(ADDR_SEED, 32'h100);
      clear_log();
      push_pkts(32'h100, 64, 3, 0);
      cfg_write(ADDR_CTRL, 32'h1);
      go_cyc = wr_cyc;
      drain("t1_drain", 50);
      chk("t1_nbeats", 512'(acc_cyc.size()), 512'd3);
      if (acc_cyc.size() >= 3) begin
         chk("t1_go_latency", 512'(acc_cyc[0]), 512'(go_cyc + 1));
         chk("t1_back_to_back", 512'(acc_cyc[2]), 512'(go_cyc + 3));
         chk("t1_b0_lane0", 512'(acc_l0[0]), 512'h100);
         chk("t1_b0_lane15", 512'(acc_l15[0]), 512'h10F);
         chk("t1_b2_lane0", 512'(acc_l0[2]), 512'h120);
      end
      cfg_check("t1_pkts", ADDR_PKTS, 32'd3);

      // three-beat packet with partial keep
      cfg_write(ADDR_LEN, 32'd130);
      cfg_write(ADDR_NPKT, 32'd1);
      cfg_write(ADDR_SEED, 32'h0);
      clear_log();
      push_pkts(32'h0, 130, 1, 0);
      cfg_write(ADDR_CTRL, 32'h1);
      drain("t2_drain", 50);
      chk("t2_nbeats", 512'(acc_cyc.size()), 512'd3);
      if (acc_cyc.size() >= 3) begin
         chk("t2_last_keep", 512'(acc_keep[2]), 512'h3);
         chk("t2_last_user", 512'(acc_user[2]), 512'({32'd2, 32'd0}));
      end
      cfg_check("t2_beats", ADDR_BEATS, 32'd3);
      cfg_check("t2_ctrl_idle", ADDR_CTRL, 32'd0);

      // random backpressure, seed near wrap, go while busy ignored
      cfg_write(ADDR_LEN, 32'd200);
      cfg_write(ADDR_NPKT, 32'd4);
      cfg_write(ADDR_SEED, 32'hFFFF_FFF0);
      clear_log();
      push_pkts(32'hFFFF_FFF0, 200, 4, 0);
      rnd_ready = 1'b1;
      cfg_write(ADDR_CTRL, 32'h1);
      cfg_write(ADDR_CTRL, 32'h1);
      drain("t3_drain", 400);
      rnd_ready = 1'b0;
      chk("t3_nbeats", 512'(acc_cyc.size()), 512'd16);
      if (acc_cyc.size() >= 16) chk("t3_wrap_lane0", 512'(acc_l0[15]), 512'h0000_00E0);
      cfg_check("t3_beats", ADDR_BEATS, 32'd16);
      cfg_check("t3_pkts", ADDR_PKTS, 32'd4);

      // inter-packet gap of 5 cycles
      cfg_write(ADDR_LEN, 32'd64);
      cfg_write(ADDR_NPKT, 32'd2);
      cfg_write(ADDR_GAP, 32'd5);
      cfg_write(ADDR_SEED, 32'h0);
      clear_log();
      push_pkts(32'h0, 64, 2, 0);
      cfg_write(ADDR_CTRL, 32'h1);
      drain("t4_drain", 50);
      chk("t4_nbeats", 512'(acc_cyc.size()), 512'd2);
      if (acc_cyc.size() >= 2) chk("t4_gap_cycles", 512'(acc_cyc[1] - acc_cyc[0] - 1), 512'd5);

      // continuous run stopped mid-packet
      cfg_write(ADDR_GAP, 32'd0);
      cfg_write(ADDR_NPKT, 32'd0);
      cfg_write(ADDR_LEN, 32'd256);
      cfg_write(ADDR_SEED, 32'h1000);
      clear_log();
      push_pkts(32'h1000, 256, 1, 0);
      cfg_write(ADDR_CTRL, 32'h3);
      cfg_write(ADDR_CTRL, 32'h6);
      drain("t5_drain", 50);
      repeat (10) @(posedge clk);
      chk("t5_nbeats", 512'(acc_cyc.size()), 512'd4);
      cfg_check("t5_ctrl", ADDR_CTRL, 32'h2);
      cfg_check("t5_pkts", ADDR_PKTS, 32'd1);

      // reset during SEND
      cfg_write(ADDR_SEED, 32'h500);
      clear_log();
      push_pkts(32'h500, 256, 1, 0);
      cfg_write(ADDR_CTRL, 32'h3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ctl_out", 512'({ots_valid, ots_last, ots_keep, ots_user, cfg_ack, cfg_rdata}), 512'd0);
      chk("t6_rst_data", ots_data, 512'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      cfg_check("t6_len", ADDR_LEN, 32'd64);
      cfg_check("t6_seed", ADDR_SEED, 32'd0);
      cfg_check("t6_npkt", ADDR_NPKT, 32'd0);
      cfg_check("t6_ctrl", ADDR_CTRL, 32'd0);
      repeat (10) @(posedge clk);
      chk("t6_no_output", 512'(acc_cyc.size()), 512'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
